pipe_hold_sequencer: RTL and testbench
======================================

// Module: pipe_hold_sequencer
// PURPOSE
//  Registered successor to the combinational hold/jump priority logic. Sequences pipeline
//  stalls, multi-cycle post-jump flushes and the JTAG debug-halt drain/ack handshake.
//  Sits beside the core pipeline: requests come from ex, clint, rib and jtag; it drives
//  pc_reg (jump) and every pipeline register stage (hold, flush).
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_o stays high after a jump, jump cycle included (>=1)
//  DRAIN_CYCLES  3   cycles of fetch-only hold before a JTAG halt is acknowledged (>=1)
//  CNT_W         2   width of the internal down-counter; must hold max(FLUSH,DRAIN)-1
// PORTS
//  clk              in   1   core clock
//  rst              in   1   asynchronous reset, active-low
//  jump_req_i       in   1   ex requests a jump/branch redirect
//  jump_addr_i      in   32  redirect target
//  hold_ex_i        in   1   ex multi-cycle stall (div, csr)
//  hold_clint_i     in   1   clint interrupt-entry stall
//  hold_rib_i       in   1   bus busy; stall fetch only
//  jtag_halt_req_i  in   1   debugger halt request, level
//  jump_flag_o      out  1   redirect pc_reg, same cycle as jump_req_i
//  jump_addr_o      out  32  redirect target to pc_reg
//  hold_flag_o      out  3   Hold_None/Hold_Pc/Hold_If/Hold_Id (000/001/010/011)
//  flush_o          out  1   kill contents of if_id and id_ex
//  jtag_halt_ack_o  out  1   registered: core drained and halted
//  busy_o           out  1   state != RUN
//  stall_cnt_o      out  32  perf: cycles with hold_flag_o != Hold_None (see CONFIGURATION)
//  flush_cnt_o      out  32  perf: cycles with flush_o == 1
// BEHAVIOUR
//  Reset: state=RUN, cnt=0, jtag_halt_ack_o=0, perf counters 0. While rst low all
//   combinational outputs are forced low: jump_flag_o=0, jump_addr_o=0,
//   hold_flag_o=Hold_None, flush_o=0, busy_o=0. Reset mid-flush/drain returns to RUN.
//  FSM states: RUN, FLUSH, DRAIN, HALTED. jump_*/hold/flush outputs are combinational
//   from state+inputs (0-cycle latency); ack is registered (1 cycle after entering HALTED).
//  RUN, priority jump > ex|clint > rib > jtag:
//   jump_req_i: jump_flag_o=1, jump_addr_o=jump_addr_i, flush_o=1; ->FLUSH, cnt=FLUSH_CYCLES-1
//     (FLUSH_CYCLES==1: stay RUN).
//   hold_ex_i|hold_clint_i: hold_flag_o=Hold_Id; stay RUN.
//   hold_rib_i: hold_flag_o=Hold_Pc; stay RUN.
//   jtag_halt_req_i: hold_flag_o=Hold_Pc; ->DRAIN, cnt=DRAIN_CYCLES-1.
//  FLUSH: flush_o=1, hold_flag_o=Hold_None (or Hold_Id if ex|clint hold); cnt-- per cycle;
//   cnt==0 -> RUN. New jump_req_i restarts: pass addr, cnt=FLUSH_CYCLES-1. jtag deferred.
//  DRAIN: hold_flag_o=Hold_Pc; ex|clint hold -> Hold_Id and cnt frozen; jump_req_i honoured
//   as in RUN, then cnt reloaded to DRAIN_CYCLES-1 and flush_o=1 that cycle; jtag req drop
//   -> RUN same cycle (abort, no ack); cnt==0 and no hold -> HALTED.
//  HALTED: hold_flag_o=Hold_Id, jtag_halt_ack_o=1 from next edge; jump_req_i ignored;
//   jtag_halt_req_i low -> RUN, ack low on following edge.
//  Counter never underflows; no wrap. busy_o=1 in FLUSH, DRAIN, HALTED.
// CONFIGURATION
//  PIPE_HOLD_SEQ_PERF_EN defined: stall_cnt_o/flush_cnt_o count as above, saturate at
//   32'hFFFF_FFFF, cleared by reset. Undefined: both ports tied to 32'h0, no flops.
// STRUCTURE
//  defines.v: Hold_* encodings, JumpEnable/HoldEnable, Hold_Flag_Bus, new Hold_Seq_State_Bus
//   and state encodings HSEQ_RUN/FLUSH/DRAIN/HALTED.
//  Sub-module sat_cnt32 (saturating enable counter), instantiated twice under the macro.
// TESTING
//  Reset low with all inputs high -> all outputs 0; release -> RUN, busy_o=0.
//  jump_req_i 1 cycle, addr 32'h0000_0100 -> jump_flag_o=1 same cycle, flush_o high 2 cycles.
//  hold_ex_i and hold_rib_i both high -> hold_flag_o=3'b011; drop ex -> 3'b001.
//  jtag req held -> 3 cycles Hold_Pc, then HALTED, ack=1 one cycle later; drop req -> ack 0.
//  DRAIN with hold_ex_i high 4 cycles -> cnt frozen, ack delayed by exactly 4 cycles.
//  Jump on 2nd FLUSH cycle -> new addr passed, flush_o extended 2 more cycles; perf flush_cnt=3.

Source files
------------

// File: rtl/pipe_hold_sequencer_pkg.sv
// Shared encodings for the pipeline hold/flush sequencer: hold-flag values and FSM states.
package pipe_hold_sequencer_pkg;

    localparam int unsigned HOLD_FLAG_W = 3;

    localparam logic [HOLD_FLAG_W-1:0] HOLD_NONE = 3'b000;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_PC   = 3'b001;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_IF   = 3'b010;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_ID   = 3'b011;

    localparam logic JUMP_ENABLE = 1'b1;
    localparam logic HOLD_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        HSEQ_RUN    = 2'b00,
        HSEQ_FLUSH  = 2'b01,
        HSEQ_DRAIN  = 2'b10,
        HSEQ_HALTED = 2'b11
    } hseq_state_e;

endpackage

// File: rtl/pipe_hold_sequencer_sat_cnt32.sv
// 32-bit saturating event counter; with EN=0 it collapses to a constant zero and holds no flops.
module sat_cnt32 #(
    parameter bit EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    if (EN) begin : g_cnt
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count <= '0;
            end else if (en && (count != '1)) begin
                count <= count + 32'd1;
            end
        end
    end else begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, rst, en};
        assign count     = '0;
    end

endmodule

// File: rtl/pipe_hold_sequencer.sv
// Registered hold/jump/flush sequencer with JTAG halt drain/ack handshake.
// Perf counters are enabled by defining PIPE_HOLD_SEQ_PERF_EN.
module pipe_hold_sequencer
    import pipe_hold_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        hold_rib_i,
    input  logic        jtag_halt_req_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic        flush_o,
    output logic        jtag_halt_ack_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

`ifdef PIPE_HOLD_SEQ_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    hseq_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ack;
    logic             jump_flag, flush;
    logic [31:0]      jump_addr;
    logic [2:0]       hold_flag;
    logic             hold_id;

    assign hold_id = hold_ex_i | hold_clint_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HSEQ_RUN;
            cnt   <= '0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= (state == HSEQ_HALTED) && jtag_halt_req_i;
        end
    end

    // Counters exit on the cycle whose decrement would reach zero, so the
    // loaded value plus the entering cycle spans exactly *_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        jump_flag = 1'b0;
        jump_addr = '0;
        hold_flag = HOLD_NONE;
        flush     = 1'b0;
        if ((state == HSEQ_RUN) || ((state == HSEQ_DRAIN) && !jtag_halt_req_i)) begin
            state_nxt = HSEQ_RUN;
            cnt_nxt   = '0;
            if (jump_req_i) begin
                jump_flag = JUMP_ENABLE;
                jump_addr = jump_addr_i;
                flush     = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = HSEQ_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end else if (hold_id) begin
                hold_flag = HOLD_ID;
            end else if (hold_rib_i) begin
                hold_flag = HOLD_PC;
            end else if (jtag_halt_req_i) begin
                hold_flag = HOLD_PC;
                state_nxt = HSEQ_DRAIN;
                cnt_nxt   = DRAIN_LOAD;
            end
        end else begin
            unique case (state)
                HSEQ_FLUSH: begin
                    flush = 1'b1;
                    if (hold_id) hold_flag = HOLD_ID;
                    if (jump_req_i) begin
                        jump_flag = JUMP_ENABLE;
                        jump_addr = jump_addr_i;
                        cnt_nxt   = FLUSH_LOAD;
                    end else if (cnt <= CNT_W'(1)) begin
                        state_nxt = HSEQ_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                HSEQ_DRAIN: begin
                    hold_flag = HOLD_PC;
                    if (jump_req_i) begin
                        jump_flag = JUMP_ENABLE;
                        jump_addr = jump_addr_i;
                        flush     = 1'b1;
                        cnt_nxt   = DRAIN_LOAD;
                    end else if (hold_id) begin
                        hold_flag = HOLD_ID;
                    end else if (cnt <= CNT_W'(1)) begin
                        state_nxt = HSEQ_HALTED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                HSEQ_HALTED: begin
                    hold_flag = HOLD_ID;
                    if (!jtag_halt_req_i) state_nxt = HSEQ_RUN;
                end
                default: begin
                    state_nxt = HSEQ_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign jump_flag_o     = rst & jump_flag;
    assign jump_addr_o     = rst ? jump_addr : '0;
    assign hold_flag_o     = rst ? hold_flag : HOLD_NONE;
    assign flush_o         = rst & flush;
    assign busy_o          = rst & (state != HSEQ_RUN);
    assign jtag_halt_ack_o = ack;

    sat_cnt32 #(.EN(PERF_EN)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (hold_flag_o != HOLD_NONE),
        .count (stall_cnt_o)
    );

    sat_cnt32 #(.EN(PERF_EN)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_o),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hold_sequencer.sv
// Directed self-checking bench for pipe_hold_sequencer (default parameters).
module tb_pipe_hold_sequencer;

`ifdef PIPE_HOLD_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req_i, hold_ex_i, hold_clint_i, hold_rib_i, jtag_halt_req_i;
    logic [31:0] jump_addr_i;
    logic        jump_flag_o, flush_o, jtag_halt_ack_o, busy_o;
    logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;
    logic [2:0]  hold_flag_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pipe_hold_sequencer #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .hold_ex_i       (hold_ex_i),
        .hold_clint_i    (hold_clint_i),
        .hold_rib_i      (hold_rib_i),
        .jtag_halt_req_i (jtag_halt_req_i),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .hold_flag_o     (hold_flag_o),
        .flush_o         (flush_o),
        .jtag_halt_ack_o (jtag_halt_ack_o),
        .busy_o          (busy_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        jump_req_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF; hold_ex_i = 1'b1;
        hold_clint_i = 1'b1; hold_rib_i = 1'b1; jtag_halt_req_i = 1'b1;
        #22;
        chk("rst_jump_flag", jump_flag_o, 0);
        chk("rst_jump_addr", jump_addr_o, 0);
        chk("rst_hold", hold_flag_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ack", jtag_halt_ack_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        jump_req_i = 1'b0; hold_ex_i = 1'b0; hold_clint_i = 1'b0;
        hold_rib_i = 1'b0; jtag_halt_req_i = 1'b0; jump_addr_i = '0;
        @(negedge clk); rst = 1'b1;
        cyc();
        chk("run_busy", busy_o, 0);
        chk("run_hold", hold_flag_o, 0);

        // Single jump: flush for two cycles.
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100; #1;
        chk("jmp_flag", jump_flag_o, 1);
        chk("jmp_addr", jump_addr_o, 32'h100);
        chk("jmp_flush0", flush_o, 1);
        cyc();
        jump_req_i = 1'b0; #1;
        chk("jmp_flush1", flush_o, 1);
        chk("jmp_flag_off", jump_flag_o, 0);
        chk("jmp_busy", busy_o, 1);
        cyc();
        chk("jmp_flush2", flush_o, 0);
        chk("jmp_busy_end", busy_o, 0);
        chk("jmp_flush_cnt", flush_cnt_o, PERF ? 32'd2 : 32'd0);

        // Hold priority.
        hold_ex_i = 1'b1; hold_rib_i = 1'b1; #1;
        chk("hold_ex_rib", hold_flag_o, 3'b011);
        cyc();
        hold_ex_i = 1'b0; #1;
        chk("hold_rib", hold_flag_o, 3'b001);
        cyc();
        hold_rib_i = 1'b0; hold_clint_i = 1'b1; #1;
        chk("hold_clint", hold_flag_o, 3'b011);
        cyc();
        hold_clint_i = 1'b0; #1;
        chk("hold_none", hold_flag_o, 3'b000);

        // JTAG halt: three Hold_Pc cycles, HALTED, ack one cycle later.
        jtag_halt_req_i = 1'b1; #1;
        chk("jt_c0_hold", hold_flag_o, 3'b001);
        cyc();
        chk("jt_c1_hold", hold_flag_o, 3'b001);
        chk("jt_c1_busy", busy_o, 1);
        cyc();
        chk("jt_c2_hold", hold_flag_o, 3'b001);
        chk("jt_c2_ack", jtag_halt_ack_o, 0);
        cyc();
        chk("jt_c3_hold", hold_flag_o, 3'b011);
        chk("jt_c3_ack", jtag_halt_ack_o, 0);
        cyc();
        chk("jt_c4_ack", jtag_halt_ack_o, 1);
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0444; #1;
        chk("jt_jump_ignored", jump_flag_o, 0);
        chk("jt_flush_ignored", flush_o, 0);
        cyc();
        jump_req_i = 1'b0; jtag_halt_req_i = 1'b0; #1;
        chk("jt_drop_hold", hold_flag_o, 3'b011);
        chk("jt_drop_ack", jtag_halt_ack_o, 1);
        cyc();
        chk("jt_ack_low", jtag_halt_ack_o, 0);
        chk("jt_busy_low", busy_o, 0);
        chk("jt_stall_cnt", stall_cnt_o, PERF ? 32'd9 : 32'd0);

        // DRAIN frozen by ex hold for four cycles.
        jtag_halt_req_i = 1'b1;
        cyc();
        hold_ex_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("dr_frozen_hold", hold_flag_o, 3'b011);
            chk("dr_frozen_busy", busy_o, 1);
            cyc();
        end
        hold_ex_i = 1'b0; #1;
        chk("dr_c5_hold", hold_flag_o, 3'b001);
        cyc();
        chk("dr_c6_hold", hold_flag_o, 3'b001);
        cyc();
        chk("dr_c7_halted", hold_flag_o, 3'b011);
        chk("dr_c7_ack", jtag_halt_ack_o, 0);
        cyc();
        chk("dr_c8_ack", jtag_halt_ack_o, 1);

        // Asynchronous reset mid-halt returns to RUN.
        rst = 1'b0; #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ack", jtag_halt_ack_o, 0);
        chk("mid_rst_hold", hold_flag_o, 0);
        jtag_halt_req_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        cyc();
        chk("post_rst_busy", busy_o, 0);

        // Jump restarted on the second flush cycle.
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0200; #1;
        chk("rj_c0_addr", jump_addr_o, 32'h200);
        cyc();
        jump_addr_i = 32'h0000_0300; #1;
        chk("rj_c1_flag", jump_flag_o, 1);
        chk("rj_c1_addr", jump_addr_o, 32'h300);
        chk("rj_c1_flush", flush_o, 1);
        cyc();
        jump_req_i = 1'b0; hold_ex_i = 1'b1; #1;
        chk("rj_c2_flush", flush_o, 1);
        chk("rj_c2_hold", hold_flag_o, 3'b011);
        cyc();
        hold_ex_i = 1'b0; #1;
        chk("rj_c3_flush", flush_o, 0);
        chk("rj_c3_busy", busy_o, 0);
        chk("rj_flush_cnt", flush_cnt_o, PERF ? 32'd3 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
